// File: rtl/layer_out_framer_pkg.sv
// Shared types for the layer output framer: channel data, pixel vector and
// framer state encoding.
package layer_out_framer_pkg;

   localparam int CHANNEL_NUM = 128;
   localparam int DATA_WIDTH  = 16;

   typedef logic signed [DATA_WIDTH-1:0] data_t;
   typedef data_t [CHANNEL_NUM-1:0]      vec_t;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      STREAM
   } state_t;

   // Counter width for a square frame of fm_width pixels per side.
   function automatic int cnt_width(input int fm_width);
      return (fm_width > 1) ? $clog2(fm_width) : 1;
   endfunction

endpackage

// File: rtl/layer_out_framer_if.sv
// Pixel stream bus between an upstream layer and the framer. The master
// drives frame sync and pixels; the slave (the framer) returns the
// re-framed stream and status.
interface layer_out_framer_if;
   import layer_out_framer_pkg::*;

   logic vs_in;
   logic stride2_en;
   logic data_in_valid;
   vec_t data_in;

   logic verticle_sync;
   logic data_out_valid;
   vec_t data_out;
   logic frame_done;
   logic sync_err;

   modport master (
      output vs_in, stride2_en, data_in_valid, data_in,
      input  verticle_sync, data_out_valid, data_out, frame_done, sync_err
   );

   modport slave (
      input  vs_in, stride2_en, data_in_valid, data_in,
      output verticle_sync, data_out_valid, data_out, frame_done, sync_err
   );

endinterface

// File: rtl/layer_out_framer_raster_counter.sv
// Raster-order col/row counter for a square frame. A clear on the same
// cycle as an increment makes the current pixel (0,0), so all flags are
// computed from the post-clear position.
module raster_counter
   import layer_out_framer_pkg::*;
#(
   parameter int FM_WIDTH = 56
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,       // start of a new frame
   input  logic i_inc,       // a pixel is counted this cycle
   output logic o_last,      // current pixel is (FM_WIDTH-1, FM_WIDTH-1)
   output logic o_even,      // current pixel has even row and even col
   output logic o_last_even  // current pixel is the last even/even one
);

   localparam int CW = cnt_width(FM_WIDTH);
   localparam logic [CW-1:0] LAST      = CW'(FM_WIDTH - 1);
   localparam logic [CW-1:0] LAST_EVEN = CW'(FM_WIDTH - 2);

   logic [CW-1:0] r_col;
   logic [CW-1:0] r_row;
   logic [CW-1:0] w_col;
   logic [CW-1:0] w_row;

   // Position of the pixel being counted this cycle.
   always_comb begin
      w_col = i_clr ? '0 : r_col;
      w_row = i_clr ? '0 : r_row;
   end

   assign o_last      = (w_col == LAST) && (w_row == LAST);
   assign o_even      = ~w_col[0] & ~w_row[0];
   assign o_last_even = (w_col == LAST_EVEN) && (w_row == LAST_EVEN);

   // Advance col with wrap into row; counters hold during input gaps.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_inc) begin
         if (w_col == LAST) begin
            r_col <= '0;
            r_row <= (w_row == LAST) ? '0 : w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
      end else if (i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end
   end

endmodule

// File: rtl/layer_out_framer.sv
// Layer output framer: counts incoming pixel vectors in raster order,
// optionally keeps only even/even pixels (stride 2), and re-emits them
// through a two-register pipeline with a fresh frame-start pulse, a
// frame-done pulse and a sticky framing-error flag.
module layer_out_framer
   import layer_out_framer_pkg::*;
#(
   parameter int FM_WIDTH = 56
) (
   input  logic              clk,
   input  logic              rstn,
   layer_out_framer_if.slave bus
);

   state_t r_state;
   state_t w_state_nxt;

   logic r_s2;
   logic r_first_pend;
   logic r_err;

   logic w_last;
   logic w_even;
   logic w_last_even;

   logic w_s2;
   logic w_count;
   logic w_pass;
   logic w_last_fwd;
   logic w_first;
   logic w_err_set;

   logic r_s1_valid;
   logic r_s1_last;
   logic r_vsync;
   vec_t r_s1_data;

   logic r_out_valid;
   logic r_done;
   vec_t r_out_data;

   // A sync arriving with a pixel applies to that pixel, so the stride
   // select and first-pixel marker are bypassed from the inputs.
   assign w_s2       = bus.vs_in ? bus.stride2_en : r_s2;
   assign w_count    = bus.data_in_valid & (bus.vs_in | (r_state != IDLE));
   assign w_pass     = w_count & (~w_s2 | w_even);
   assign w_last_fwd = w_pass & (w_s2 ? w_last_even : w_last);
   assign w_first    = bus.vs_in | r_first_pend;
   assign w_err_set  = (bus.vs_in & (r_state == STREAM)) |
                       (bus.data_in_valid & ~bus.vs_in & (r_state == IDLE));

   raster_counter #(
      .FM_WIDTH (FM_WIDTH)
   ) u_raster_counter (
      .clk         (clk),
      .rstn        (rstn),
      .i_clr       (bus.vs_in),
      .i_inc       (w_count),
      .o_last      (w_last),
      .o_even      (w_even),
      .o_last_even (w_last_even)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block order.
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: a counted pixel moves to STREAM (or back to IDLE on
   // the frame's last pixel); a sync without a pixel (re-)arms.
   always_comb begin
      // NOTE: default first so no path leaves w_state_nxt unassigned,
      // which would infer a latch.
      w_state_nxt = r_state;
      if (w_count) begin
         w_state_nxt = w_last ? IDLE : STREAM;
      end else if (bus.vs_in) begin
         w_state_nxt = ARMED;
      end
   end

   // Per-frame control: stride latch, pending frame-start pulse, sticky error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s2         <= 1'b0;
         r_first_pend <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         if (bus.vs_in) begin
            r_s2         <= bus.stride2_en;
            r_first_pend <= ~w_pass;
         end else if (w_pass) begin
            r_first_pend <= 1'b0;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   // Two-stage pixel pipeline; the frame-start pulse leaves with stage 1 so
   // it leads the first forwarded pixel on the output by one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_vsync     <= 1'b0;
         // NOTE: the wide data registers are reset too because the output
         // lanes must read zero out of reset, not just the valid flags.
         r_s1_data   <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_s1_valid  <= w_pass;
         r_s1_last   <= w_last_fwd;
         r_vsync     <= w_pass & w_first;
         if (w_pass) begin
            r_s1_data <= bus.data_in;
         end
         r_out_valid <= r_s1_valid;
         r_done      <= r_s1_last;
         if (r_s1_valid) begin
            r_out_data <= r_s1_data;
         end
      end
   end

   assign bus.verticle_sync  = r_vsync;
   assign bus.data_out_valid = r_out_valid;
   assign bus.data_out       = r_out_data;
   assign bus.frame_done     = r_done;
   assign bus.sync_err       = r_err;

endmodule

// File: doc/layer_out_framer.md
# layer_out_framer

Frame framer on the output of a layer top. Takes the layer's per-pixel channel vectors and counts them in raster order. Optionally decimates them by 2 in each direction. Re-emits them with a fresh `verticle_sync` so the stream can drive the next layer's `wrapper`. It also detects framing errors: pixels outside a frame, a premature sync, or an overrun.

## Interface
- `CHANNEL_NUM`, 128: channels per pixel vector.
- `DATA_WIDTH`, 16: signed width of each channel value.
- `FM_WIDTH`, 56: input frame width and height in pixels; must be even.
- `clk`  in  1: the single clock.
- `rstn`  in  1: reset, asynchronous assert, active-low.
- `vs_in`  in  1: frame-start pulse from the upstream layer's `vs_next`.
- `stride2_en`  in  1: decimation select; sampled only on the cycle `vs_in` is seen.
- `data_in_valid`  in  1: upstream pixel valid.
- `data_in`  in  `CHANNEL_NUM` x `DATA_WIDTH` signed: upstream pixel vector.
- `verticle_sync`  out  1: one-cycle frame-start pulse to the next layer.
- `data_out_valid`  out  1: output pixel valid.
- `data_out`  out  `CHANNEL_NUM` x `DATA_WIDTH` signed: output pixel vector.
- `frame_done`  out  1: one-cycle pulse when the last output pixel is emitted.
- `sync_err`  out  1: sticky error flag; cleared only by `rstn`.

## Operation
- States: IDLE, ARMED, STREAM.
- IDLE to ARMED on `vs_in`. Latch `stride2_en` into `s2`. Clear `col` and `row`, each `$clog2(FM_WIDTH)` bits.
- ARMED to STREAM on the first `data_in_valid`. That pixel is counted as (row 0, col 0).
- Counting happens in ARMED and STREAM on each valid input.
  - `col` increments; at `FM_WIDTH-1` it wraps to 0 and `row` increments.
  - On the pixel at (`FM_WIDTH-1`, `FM_WIDTH-1`), go to IDLE.
- Pass rule:
  - With `s2`=0, every counted pixel is forwarded.
  - With `s2`=1, a pixel is forwarded only if `row[0]`=0 and `col[0]`=0. This gives (`FM_WIDTH`/2)^2 outputs per frame.
- `verticle_sync` pulses once per frame, one cycle before the first forwarded pixel appears on `data_out`.
- `frame_done` is asserted in the same cycle as the last forwarded pixel's `data_out_valid`.
- Errors set `sync_err`:
  - `data_in_valid` in IDLE: the pixel is dropped.
  - `vs_in` while in STREAM: the current frame is aborted, no `frame_done` is issued, the block re-arms as for a normal `vs_in`, and pixels already in the pipeline still drain.
- A `vs_in` in ARMED simply re-arms; it is not an error.
- `vs_in` and `data_in_valid` in the same cycle: `vs_in` takes priority. The pixel is treated as arriving after the sync, i.e. it becomes pixel (0,0) of the new frame.
- Data is never modified. There is no arithmetic on the data path; only counters compare.

## Timing
- Pipeline: input register (stage 1), then output register (stage 2).
- A forwarded pixel accepted at cycle t appears on `data_out` with `data_out_valid` at t+2.
- `verticle_sync` for that frame's first forwarded pixel is at t+1.
- No backpressure. At most one pixel per cycle, back-to-back pixels allowed, throughput 1.
- Reset values: state IDLE, counters 0, `s2` 0. All outputs 0, including `data_out` lanes, `verticle_sync`, `data_out_valid`, `frame_done` and `sync_err`.
- Reset mid-frame: everything is cleared immediately, in-flight pixels are lost, and no pulses are emitted.
- Gaps between valids are arbitrary; the counters hold during gaps.

## Structure
- Shared layer package holds:
  - the signed data typedef (`DATA_WIDTH`);
  - the `CHANNEL_NUM`-wide vector typedef;
  - the state enum {IDLE, ARMED, STREAM}.
- One natural sub-module, `raster_counter`: `col`/`row` counters with wrap, a last-pixel flag, and an even/even flag.
- The top holds the FSM, the pass/decimate logic and the two-stage vector pipeline.

## Test plan
- **Full frame, `s2`=0, `FM_WIDTH`=4:** `vs_in`, then 16 back-to-back valids with lane 0 = 0..15 → `verticle_sync` one cycle before 16 consecutive outputs with lane 0 = 0..15, `frame_done` with value 15, `sync_err`=0.
- **Stride 2, `FM_WIDTH`=4:** `stride2_en`=1 at `vs_in`, 16 pixels with random gaps → exactly 4 outputs carrying inputs 0, 2, 8, 10; `frame_done` on the output carrying 10.
- **Orphan pixel:** valid asserted in IDLE → no output, `sync_err`=1 and held until reset.
- **Premature sync:** `vs_in` after 7 of 16 pixels, then 16 more pixels → 7 outputs from the old frame, a new `verticle_sync`, 16 new outputs, one `frame_done`, `sync_err`=1.
- **Simultaneous events:** `vs_in` and valid with value 42 in the same cycle from IDLE → 42 is output as pixel (0,0), preceded by `verticle_sync`.
- **Reset mid-frame:** `rstn` dropped after 5 pixels → all outputs are 0 at once; after release a clean frame is framed correctly.
